// File: rtl/uart_fifo.sv
// Buffered CPU serial port: RX/TX FIFOs between the I/O bus and a paced host
// interface, with sticky error flags, flush and a level interrupt.
module uart_fifo #(
  parameter int unsigned RX_DEPTH = 4,
  parameter int unsigned TX_DEPTH = 4,
  parameter int unsigned POLL_DIV = 16,
  parameter int unsigned TX_DIV   = 1,
  parameter bit          RX_FLOW  = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  inout  logic [7:0] io_bus,
  input  logic       sel_data,
  input  logic       sel_status,
  input  logic       rnw,
  output logic       irq,
  // Host side: a poll strobe fetches one character; a send strobe hands one over.
  output logic       host_poll_c,
  input  logic       host_rx_valid,
  input  logic [7:0] host_rx_char,
  output logic       host_tx_send_c,
  output logic [7:0] host_tx_char_c
);

  localparam int unsigned RX_AW = $clog2(RX_DEPTH);
  localparam int unsigned RX_CW = RX_AW + 1;
  localparam int unsigned TX_AW = $clog2(TX_DEPTH);
  localparam int unsigned TX_CW = TX_AW + 1;
  localparam int unsigned PW    = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
  localparam int unsigned DW    = (TX_DIV > 1) ? $clog2(TX_DIV) : 1;

  logic [7:0]       rx_mem [RX_DEPTH];
  logic [7:0]       tx_mem [TX_DEPTH];
  logic [RX_AW-1:0] rx_rd, rx_wr;
  logic [TX_AW-1:0] tx_rd, tx_wr;
  logic [RX_CW-1:0] rx_count;
  logic [TX_CW-1:0] tx_count;
  logic [PW-1:0]    poll_cnt;
  logic [DW-1:0]    tx_cnt;
  logic             rx_ovf, tx_drop, rxie, txie;

  logic rd_data, rd_status, wr_data, wr_status, flush;
  logic rx_empty, rx_full, tx_empty, tx_full;
  logic poll_hit, tx_hit, rx_pop, rx_push, rx_ovf_set, tx_push, tx_drop_set;
  logic [7:0] status, rd_val;

  // Bus decode; the data select wins when both are asserted.
  assign rd_data   = rnw & sel_data;
  assign rd_status = rnw & sel_status & ~sel_data;
  assign wr_data   = ~rnw & sel_data;
  assign wr_status = ~rnw & sel_status & ~sel_data;
  assign flush     = wr_status & io_bus[7];

  assign rx_empty = (rx_count == '0);
  assign rx_full  = (rx_count == RX_CW'(RX_DEPTH));
  assign tx_empty = (tx_count == '0);
  assign tx_full  = (tx_count == TX_CW'(TX_DEPTH));
  assign poll_hit = (poll_cnt == PW'(POLL_DIV - 1));
  assign tx_hit   = (tx_cnt == DW'(TX_DIV - 1));

  // A same-cycle pop frees a slot for the polled character.
  assign rx_pop      = rd_data & ~rx_empty;
  assign host_poll_c = rst_n & poll_hit & ((RX_FLOW == 1'b0) | ~rx_full | rx_pop);
  assign rx_push     = host_poll_c & host_rx_valid & (~rx_full | rx_pop);
  assign rx_ovf_set  = host_poll_c & host_rx_valid & rx_full & ~rx_pop;

  // Drain looks only at the registered count, so a byte written this cycle waits.
  assign host_tx_send_c = rst_n & tx_hit & ~tx_empty;
  assign host_tx_char_c = tx_mem[tx_rd];
  assign tx_push        = wr_data & (~tx_full | host_tx_send_c);
  assign tx_drop_set    = wr_data & tx_full & ~host_tx_send_c;

  assign status = {1'b0, txie, rxie, tx_empty, tx_drop, rx_ovf, ~tx_full, ~rx_empty};
  assign rd_val = sel_data ? (rx_empty ? 8'h00 : rx_mem[rx_rd]) : status;
  assign io_bus = (rnw & (sel_data | sel_status)) ? rd_val : 8'bz;

  // FIFO storage carries no reset; pointers and counts define validity.
  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wr] <= host_rx_char;
    if (tx_push) tx_mem[tx_wr] <= io_bus;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_rd    <= '0;
      rx_wr    <= '0;
      rx_count <= '0;
      tx_rd    <= '0;
      tx_wr    <= '0;
      tx_count <= '0;
      poll_cnt <= '0;
      tx_cnt   <= '0;
      rx_ovf   <= 1'b0;
      tx_drop  <= 1'b0;
      rxie     <= 1'b0;
      txie     <= 1'b0;
      irq      <= 1'b0;
    end else begin
      poll_cnt <= poll_hit ? '0 : poll_cnt + PW'(1);
      tx_cnt   <= tx_hit ? '0 : tx_cnt + DW'(1);
      irq      <= (rxie & ~rx_empty) | (txie & tx_empty);

      if (wr_status) begin
        rxie <= io_bus[0];
        txie <= io_bus[1];
      end

      if (flush) begin
        rx_rd    <= '0;
        rx_wr    <= '0;
        rx_count <= '0;
        tx_rd    <= '0;
        tx_wr    <= '0;
        tx_count <= '0;
        rx_ovf   <= 1'b0;
        tx_drop  <= 1'b0;
      end else begin
        if (rx_push) rx_wr <= rx_wr + RX_AW'(1);
        if (rx_pop)  rx_rd <= rx_rd + RX_AW'(1);
        rx_count <= rx_count + RX_CW'(rx_push) - RX_CW'(rx_pop);
        if (tx_push)        tx_wr <= tx_wr + TX_AW'(1);
        if (host_tx_send_c) tx_rd <= tx_rd + TX_AW'(1);
        tx_count <= tx_count + TX_CW'(tx_push) - TX_CW'(host_tx_send_c);

        // Set beats the read-to-clear in the same cycle.
        if (rx_ovf_set)     rx_ovf <= 1'b1;
        else if (rd_status) rx_ovf <= 1'b0;
        if (tx_drop_set)    tx_drop <= 1'b1;
        else if (rd_status) tx_drop <= 1'b0;
      end
    end
  end

endmodule
